// File: rtl/reg_write_arbiter_if.sv
// Write-port bundle between requesters (master side) and reg_write_arbiter (slave side).
interface reg_write_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]  req_data;
  logic                      hold;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REGS-1:0]       load;
  logic [WIDTH-1:0]          wdata;
  logic                      addr_err;
  logic                      busy;

  modport master (
    output req, req_addr, req_data, hold,
    input  gnt, load, wdata, addr_err, busy
  );

  modport slave (
    input  req, req_addr, req_data, hold,
    output gnt, load, wdata, addr_err, busy
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one write port into a bank of loadable registers.
// Define REG_WRITE_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest, no pointer).
module reg_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
) (
  input logic               clk,
  input logic               rst,
  reg_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REGS-1:0] load_q, load_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic                addr_err_q, addr_err_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;

  logic [NUM_REQ-1:0]  elig;
  logic                found;
  logic [PTR_W-1:0]    win;
  logic [ADDR_W-1:0]   win_addr;

  // The requester granted this cycle is masked so a late-dropped req is not granted twice.
  assign elig = bus.req & ~gnt_q;

  always_comb begin : pick
    int idx;
    logic [PTR_W-1:0] sel;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = PTR_W'(idx);
      if (!found && elig[sel]) begin
        found = 1'b1;
        win   = sel;
      end
    end
  end

  assign win_addr = bus.req_addr[int'(win)*ADDR_W +: ADDR_W];

  always_comb begin : next_state
    gnt_d      = '0;
    load_d     = '0;
    addr_err_d = 1'b0;
    wdata_d    = wdata_q;
    ptr_d      = ptr_q;
    if (!bus.hold && found) begin
      gnt_d   = NUM_REQ'(1) << win;
      wdata_d = bus.req_data[int'(win)*WIDTH +: WIDTH];
      // Out-of-range targets still get a grant so the requester is released.
      if (int'(win_addr) < NUM_REGS) load_d = NUM_REGS'(1) << win_addr;
      else addr_err_d = 1'b1;
`ifndef REG_WRITE_ARB_FIXED_PRIO_EN
      ptr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
`endif
    end
`ifdef REG_WRITE_ARB_FIXED_PRIO_EN
    ptr_d = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q      <= '0;
      load_q     <= '0;
      wdata_q    <= '0;
      addr_err_q <= 1'b0;
      ptr_q      <= '0;
    end else begin
      gnt_q      <= gnt_d;
      load_q     <= load_d;
      wdata_q    <= wdata_d;
      addr_err_q <= addr_err_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.load     = load_q;
  assign bus.wdata    = wdata_q;
  assign bus.addr_err = addr_err_q;
  assign bus.busy     = |bus.req;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: cycle scoreboard plus directed scenario tasks.
module tb_reg_write_arbiter;
  localparam int NR = 4;
  localparam int W  = 8;
  localparam int NG = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_write_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .NUM_REGS(NG), .ADDR_W(AW)) bus ();
  reg_write_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .NUM_REGS(3),  .ADDR_W(AW)) bus3 ();

  reg_write_arbiter #(.NUM_REQ(NR), .WIDTH(W), .NUM_REGS(NG), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  reg_write_arbiter #(.NUM_REQ(NR), .WIDTH(W), .NUM_REGS(3), .ADDR_W(AW)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NR-1:0] gnt;
    logic [NG-1:0] load;
    logic [W-1:0]  wdata;
    logic          addr_err;
  } exp_t;

  exp_t sb[$];
  logic [NR-1:0] m_gnt;
  logic [W-1:0]  m_wdata;
  int            m_ptr;
  logic [W-1:0]  bank [NG];

  // Reference model and register bank, evaluated on the same edges as the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_gnt   = '0;
      m_wdata = '0;
      m_ptr   = 0;
      sb.delete();
      for (int j = 0; j < NG; j++) bank[j] = '0;
    end else begin
      exp_t e;
      logic [NR-1:0] elig;
      int win;
      int a;
      for (int j = 0; j < NG; j++) if (bus.load[j]) bank[j] = bus.wdata;
      elig = bus.req & ~m_gnt;
      win  = -1;
      if (!bus.hold)
        for (int k = 0; k < NR; k++)
          if (win < 0 && elig[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
      e.gnt = '0; e.load = '0; e.addr_err = 1'b0; e.wdata = m_wdata;
      if (win >= 0) begin
        e.gnt[win] = 1'b1;
        a = int'(bus.req_addr[win*AW +: AW]);
        e.wdata = bus.req_data[win*W +: W];
        if (a < NG) e.load[a] = 1'b1;
        else e.addr_err = 1'b1;
`ifndef REG_WRITE_ARB_FIXED_PRIO_EN
        m_ptr = (win + 1) % NR;
`endif
      end
      m_gnt   = e.gnt;
      m_wdata = e.wdata;
      sb.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (bus.gnt !== '0 || bus.load !== '0 || bus.wdata !== '0 || bus.addr_err !== 1'b0) begin
        errors++;
        $display("FAIL sb_reset got gnt=%b load=%b wdata=%h err=%b exp all zero",
                 bus.gnt, bus.load, bus.wdata, bus.addr_err);
      end
    end else if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (bus.gnt !== e.gnt || bus.load !== e.load || bus.wdata !== e.wdata ||
          bus.addr_err !== e.addr_err) begin
        errors++;
        $display("FAIL sb_cycle t=%0t got gnt=%b load=%b wdata=%h err=%b exp gnt=%b load=%b wdata=%h err=%b",
                 $time, bus.gnt, bus.load, bus.wdata, bus.addr_err,
                 e.gnt, e.load, e.wdata, e.addr_err);
      end
    end
  end

  task automatic next();
    @(negedge clk);
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    next();
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0; bus.req_addr = '0; bus.req_data = '0; bus.hold = 1'b0;
    bus3.req = '0; bus3.req_addr = '0; bus3.req_data = '0; bus3.hold = 1'b0;
    next(); next();
    bus.req = 4'b0101;
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL busy_in_reset got %b exp 1", bus.busy);
    end
    bus.req = '0;
    #1 rst = 1'b0;
    next();
    // Request 0 to addr 2, then hit reset during the grant cycle.
    bus.req = 4'b0001; bus.req_addr = 8'b0000_0010; bus.req_data = {24'h0, 8'hA5};
    @(posedge clk); #2;
    checks++;
    if (bus.gnt !== 4'b0001 || bus.load !== 4'b0100 || bus.wdata !== 8'hA5) begin
      errors++; $display("FAIL pre_reset_grant got gnt=%b load=%b wdata=%h exp 0001 0100 a5",
                         bus.gnt, bus.load, bus.wdata);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.gnt !== '0 || bus.load !== '0 || bus.wdata !== '0) begin
      errors++; $display("FAIL async_reset got gnt=%b load=%b wdata=%h exp zeros",
                         bus.gnt, bus.load, bus.wdata);
    end
    bus.req = '0;
    next();
    #1 rst = 1'b0;
    next();
    bus.req = 4'b0101; bus.req_addr = 8'b0001_0000; bus.req_data = {8'h0, 8'h22, 8'h0, 8'h11};
    next();
    checks++;
    if (bus.gnt !== 4'b0001 || bus.wdata !== 8'h11) begin
      errors++; $display("FAIL ptr_after_reset got gnt=%b wdata=%h exp 0001 11", bus.gnt, bus.wdata);
    end
    bus.req = 4'b0100;
    next();
    checks++;
    if (bus.gnt !== 4'b0100 || bus.load !== 4'b0010 || bus.wdata !== 8'h22) begin
      errors++; $display("FAIL second_after_reset got gnt=%b load=%b wdata=%h exp 0100 0010 22",
                         bus.gnt, bus.load, bus.wdata);
    end
    bus.req = '0;
    next();
  endtask

  task automatic test_single_write();
    bus.req = 4'b0010; bus.req_addr = 8'b0000_1100; bus.req_data = {16'h0, 8'h3C, 8'h0};
    next();
    checks++;
    if (bus.gnt !== 4'b0010 || bus.load !== 4'b1000 || bus.wdata !== 8'h3C || bus.addr_err !== 1'b0) begin
      errors++; $display("FAIL single_grant got gnt=%b load=%b wdata=%h err=%b exp 0010 1000 3c 0",
                         bus.gnt, bus.load, bus.wdata, bus.addr_err);
    end
    next();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.load !== 4'b0000 || bus.wdata !== 8'h3C) begin
      errors++; $display("FAIL single_masked got gnt=%b load=%b wdata=%h exp 0000 0000 3c",
                         bus.gnt, bus.load, bus.wdata);
    end
    checks++;
    if (bank[3] !== 8'h3C) begin
      errors++; $display("FAIL single_bank got %h exp 3c", bank[3]);
    end
    bus.req = '0;
    next();
    checks++;
    if (bus.gnt !== 4'b0000) begin
      errors++; $display("FAIL single_no_regrant got gnt=%b exp 0000", bus.gnt);
    end
  endtask

  task automatic test_fairness();
    int exp_seq [5];
    logic [W-1:0] exp_bank [NG];
`ifdef REG_WRITE_ARB_FIXED_PRIO_EN
    exp_seq  = '{0, 1, 0, 1, 0};
    exp_bank = '{8'h11, 8'h22, 8'h00, 8'h00};
`else
    exp_seq  = '{0, 1, 2, 3, 0};
    exp_bank = '{8'h11, 8'h22, 8'h33, 8'h44};
`endif
    do_reset();
    bus.req = 4'b1111; bus.req_addr = 8'b11_10_01_00; bus.req_data = 32'h44_33_22_11;
    for (int c = 0; c < 5; c++) begin
      next();
      checks++;
      if (bus.gnt !== (4'b0001 << exp_seq[c])) begin
        errors++; $display("FAIL rr_order[%0d] got gnt=%b exp idx %0d", c, bus.gnt, exp_seq[c]);
      end
      checks++;
      if ($countones(bus.gnt) > 1) begin
        errors++; $display("FAIL rr_onehot[%0d] got gnt=%b exp at most one bit", c, bus.gnt);
      end
    end
    bus.req = '0;
    next(); next();
    for (int j = 0; j < NG; j++) begin
      checks++;
      if (bank[j] !== exp_bank[j]) begin
        errors++; $display("FAIL rr_bank[%0d] got %h exp %h", j, bank[j], exp_bank[j]);
      end
    end
  endtask

  task automatic test_hold();
    bus.hold = 1'b1;
    bus.req = 4'b0100; bus.req_addr = 8'b00_01_00_00; bus.req_data = 32'h00_77_00_00;
    for (int c = 0; c < 3; c++) begin
      next();
      checks++;
      if (bus.gnt !== '0 || bus.load !== '0 || bus.busy !== 1'b1) begin
        errors++; $display("FAIL hold[%0d] got gnt=%b load=%b busy=%b exp 0000 0000 1",
                           c, bus.gnt, bus.load, bus.busy);
      end
    end
    bus.hold = 1'b0;
    next();
    checks++;
    if (bus.gnt !== 4'b0100 || bus.load !== 4'b0010 || bus.wdata !== 8'h77) begin
      errors++; $display("FAIL hold_release got gnt=%b load=%b wdata=%h exp 0100 0010 77",
                         bus.gnt, bus.load, bus.wdata);
    end
    bus.req = '0;
    next();
    bus.req = 4'b1001; bus.req_addr = 8'b11_00_00_00; bus.req_data = 32'h08_00_00_01;
    next();
    checks++;
`ifdef REG_WRITE_ARB_FIXED_PRIO_EN
    if (bus.gnt !== 4'b0001) begin
      errors++; $display("FAIL ptr_after_hold got gnt=%b exp 0001", bus.gnt);
    end
`else
    if (bus.gnt !== 4'b1000) begin
      errors++; $display("FAIL ptr_after_hold got gnt=%b exp 1000", bus.gnt);
    end
`endif
    bus.req = '0;
    next(); next();
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.req = 4'b0001; bus.req_addr = 8'b0000_0001; bus.req_data = 32'h0000_005A;
    for (int c = 0; c < 6; c++) begin
      next();
      checks++;
      if (bus.gnt !== ((c % 2 == 0) ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL solo_alternate[%0d] got gnt=%b", c, bus.gnt);
      end
    end
    bus.req = '0;
    do_reset();
    bus.req = 4'b1001; bus.req_addr = 8'b10_00_00_00; bus.req_data = 32'hC3_00_00_0C;
    for (int c = 0; c < 6; c++) begin
      next();
      checks++;
      if (bus.gnt !== ((c % 2 == 0) ? 4'b0001 : 4'b1000)) begin
        errors++; $display("FAIL req0_req3[%0d] got gnt=%b", c, bus.gnt);
      end
    end
    bus.req = '0;
    next();
  endtask

  task automatic test_same_reg();
    bus.req = 4'b0110; bus.req_addr = 8'b00_01_01_00; bus.req_data = 32'h00_B2_B1_00;
    next(); next();
    bus.req = '0;
    next();
    checks++;
    if (bank[1] !== 8'hB2) begin
      errors++; $display("FAIL same_reg got %h exp b2", bank[1]);
    end
  endtask

  task automatic test_addr_err();
    bus3.req = 4'b0001; bus3.req_addr = 8'b0000_0011; bus3.req_data = 32'h0000_00FF;
    next();
    checks++;
    if (bus3.gnt !== 4'b0001 || bus3.load !== 3'b000 || bus3.addr_err !== 1'b1 || bus3.wdata !== 8'hFF) begin
      errors++; $display("FAIL addr_err got gnt=%b load=%b err=%b wdata=%h exp 0001 000 1 ff",
                         bus3.gnt, bus3.load, bus3.addr_err, bus3.wdata);
    end
    next();
    checks++;
    if (bus3.gnt !== 4'b0000 || bus3.addr_err !== 1'b0 || bus3.load !== 3'b000) begin
      errors++; $display("FAIL addr_err_pulse got gnt=%b err=%b load=%b exp 0000 0 000",
                         bus3.gnt, bus3.addr_err, bus3.load);
    end
    bus3.req = '0;
    next();
    bus3.req = 4'b0001; bus3.req_addr = 8'b0000_0010; bus3.req_data = 32'h0000_0012;
    next();
    checks++;
    if (bus3.gnt !== 4'b0001 || bus3.load !== 3'b100 || bus3.addr_err !== 1'b0) begin
      errors++; $display("FAIL addr_ok_top got gnt=%b load=%b err=%b exp 0001 100 0",
                         bus3.gnt, bus3.load, bus3.addr_err);
    end
    bus3.req = '0;
    next();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fairness();
    test_hold();
    test_back_to_back();
    test_same_reg();
    test_addr_err();
    next(); next();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
